// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_unit_if : IR/ALU inputs and datapath control outputs   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface multicycle_control_unit_if #(
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 32
);
    logic [5:0]           OpCode;
    logic [5:0]           Funct;
    logic                 Zero;
    logic                 mem_ready;
    logic                 IorD;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 RegDst;
    logic                 MemtoReg;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic [1:0]           PCSrc;
    logic                 PCEn;
    logic [3:0]           state;
    logic                 illegal;
    logic [CNT_W-1:0]     retired;

    modport master (
        input  OpCode, Funct, Zero, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state, illegal, retired
    );

    modport slave (
        output OpCode, Funct, Zero, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, state, illegal, retired
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_unit : Moore FSM control for the MIPS multicycle path  |
// | Optional macro MULTICYCLE_CU_BNE_EN adds bne decode. Revision: 1.0        |
// +--------------------------------------------------------------------------+
module multicycle_control_unit #(
    parameter int ALUCTRL_W    = 3,
    parameter int CNT_W        = 32,
    parameter int ILLEGAL_HALT = 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    multicycle_control_unit_if.master   bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMREAD = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ILLEGAL = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_branch_cond;
    logic       w_done;

    logic       w_iord, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write;
    logic       w_src_a, w_pc_write, w_branch, w_illegal;
    logic [1:0] w_src_b, w_pc_src;
    logic [2:0] w_alu;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (bus.Funct)
            FN_ADD:  w_funct_alu = ALU_ADD;
            FN_SUB:  w_funct_alu = ALU_SUB;
            FN_AND:  w_funct_alu = ALU_AND;
            FN_OR:   w_funct_alu = ALU_OR;
            FN_SLT:  w_funct_alu = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

`ifdef MULTICYCLE_CU_BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
    logic bne_flag_q;

    // Branch sense is captured while the opcode is still decoded.
    always_ff @(posedge clk) begin
        if (rst) begin
            bne_flag_q <= 1'b0;
        end else if (state_q == S_DECODE) begin
            bne_flag_q <= (bus.OpCode == OP_BNE);
        end
    end
    assign w_branch_cond = bus.Zero ^ bne_flag_q;
`else
    assign w_branch_cond = bus.Zero;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.OpCode)
                    OP_RTYPE:     state_d = w_funct_ok ? S_EXECUTE : S_ILLEGAL;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_CU_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_d = (bus.OpCode == OP_LW) ? S_MEMREAD : S_MEMWR;
            S_MEMREAD: state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_ILLEGAL: state_d = (ILLEGAL_HALT != 0) ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that leaves its last state for FETCH.
    always_comb begin
        case (state_q)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_done = 1'b1;
            S_MEMWR: w_done = bus.mem_ready;
            default: w_done = 1'b0;
        endcase
        retired_d = w_done ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        w_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_src_a      = 1'b0;
        w_src_b      = 2'b00;
        w_alu        = ALU_AND;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                w_src_b    = 2'b01;
                w_alu      = ALU_ADD;
                w_ir_write = bus.mem_ready;
                w_pc_write = bus.mem_ready;
            end
            S_DECODE: begin
                w_src_b = 2'b11;
                w_alu   = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                w_src_a = 1'b1;
                w_src_b = 2'b10;
                w_alu   = ALU_ADD;
            end
            S_MEMREAD: w_iord = 1'b1;
            S_MEMWB: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTE: begin
                w_src_a = 1'b1;
                w_alu   = w_funct_alu;
            end
            S_ALUWB: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                w_src_a  = 1'b1;
                w_alu    = ALU_SUB;
                w_pc_src = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIWB:  w_reg_write = 1'b1;
            S_JUMP: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            S_ILLEGAL: w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Write strobes are suppressed while reset is held.
    assign bus.IorD       = w_iord;
    assign bus.MemWrite   = w_mem_write & ~rst;
    assign bus.IRWrite    = w_ir_write & ~rst;
    assign bus.RegDst     = w_reg_dst;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.RegWrite   = w_reg_write & ~rst;
    assign bus.ALUSrcA    = w_src_a;
    assign bus.ALUSrcB    = w_src_b;
    assign bus.ALUControl = ALUCTRL_W'(w_alu);
    assign bus.PCSrc      = w_pc_src;
    assign bus.PCEn       = (w_pc_write | (w_branch & w_branch_cond)) & ~rst;
    assign bus.state      = state_q;
    assign bus.illegal    = w_illegal;
    assign bus.retired    = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control_unit : vector table, corner sequences, random run   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_control_unit;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUCTRL_W(3), .CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(
        .ALUCTRL_W(3), .CNT_W(CNT_W), .ILLEGAL_HALT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         cycles;
    } vec_t;

    vec_t        tbl[10];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] ret_model  = 0;

    logic [15:0] w_outs;
    assign w_outs = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.PCSrc, bus.PCEn, bus.illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Control word per state number, straight from the state/output table.
    function automatic logic [15:0] ref_outs(input int st, input bit mr, input bit z,
                                             input logic [5:0] fn);
        logic iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, srca = 0;
        logic pcen = 0, ill = 0;
        logic [1:0] srcb = 0, pcsrc = 0;
        logic [2:0] alu = 0;
        case (st)
            0:  begin srcb = 2'b01; alu = 3'b010; irw = mr; pcen = mr; end
            1:  begin srcb = 2'b11; alu = 3'b010; end
            2:  begin srca = 1; srcb = 2'b10; alu = 3'b010; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; alu = ref_alu(fn); end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; alu = 3'b110; pcsrc = 2'b01; pcen = z; end
            9:  begin srca = 1; srcb = 2'b10; alu = 3'b010; end
            10: rw = 1;
            11: begin pcsrc = 2'b10; pcen = 1; end
            12: ill = 1;
            default: ;
        endcase
        return {iord, mw, irw, rdst, m2r, rw, srca, srcb, alu, pcsrc, pcen, ill};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        step();
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_writes", {bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite}, 0);
        step();
        rst = 1'b0;
        ret_model = 0;
        chk("rst_retired", bus.retired, ret_model);
        chk("rst_illegal", 32'(bus.illegal), 0);
    endtask

    // Random-ready walk of one instruction along its expected state path.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int cls);
        int path[$];
        int idx = 0;
        int budget = 0;
        int st;
        bit mr, z;
        bus.OpCode = op;
        bus.Funct  = fn;
        case (cls)
            0:       path = '{0, 1, 2, 3, 4};
            1:       path = '{0, 1, 2, 5};
            2:       path = '{0, 1, 6, 7};
            3:       path = '{0, 1, 9, 10};
            4:       path = '{0, 1, 8};
            5:       path = '{0, 1, 11};
            default: path = '{0, 1, 12};
        endcase
        while (idx < path.size() && budget < 100) begin
            mr = ($urandom_range(0, 3) != 0);
            z  = 1'($urandom_range(0, 1));
            bus.mem_ready = mr;
            bus.Zero      = z;
            @(negedge clk);
            st = path[idx];
            chk("rnd_state", 32'(bus.state), st);
            chk("rnd_outs", 32'(w_outs), 32'(ref_outs(st, mr, z, fn)));
            if (!((st == 0 || st == 3 || st == 5) && !mr)) idx++;
            step();
            budget++;
        end
        if (budget >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL rnd_timeout: got %0d cycles, expected under 100", budget);
        end
        if (cls >= 6) begin
            repeat (3) begin
                @(negedge clk);
                chk("rnd_ill_state", 32'(bus.state), 12);
                chk("rnd_ill_flag", 32'(bus.illegal), 1);
                chk("rnd_ill_retired", bus.retired, ret_model);
                step();
            end
            do_reset();
        end else begin
            ret_model++;
            chk("rnd_retired", bus.retired, ret_model);
        end
    endtask

    task automatic set_vec(input int i, input string n, input logic [5:0] op,
                           input logic [5:0] fn, input int c);
        tbl[i].name = n; tbl[i].op = op; tbl[i].fn = fn; tbl[i].cycles = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ill_ops[4];
        logic [5:0] r_fns[5];
        int cnt, mwc, cls;
        logic [5:0] op, fn;
        ill_ops = '{6'h3f, 6'h0c, 6'h20, 6'h03};
        r_fns   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

        set_vec(0, "lw",   6'b100011, 6'h00, 5);
        set_vec(1, "sw",   6'b101011, 6'h00, 4);
        set_vec(2, "add",  6'b000000, 6'h20, 4);
        set_vec(3, "sub",  6'b000000, 6'h22, 4);
        set_vec(4, "and",  6'b000000, 6'h24, 4);
        set_vec(5, "or",   6'b000000, 6'h25, 4);
        set_vec(6, "slt",  6'b000000, 6'h2a, 4);
        set_vec(7, "addi", 6'b001000, 6'h00, 4);
        set_vec(8, "beq",  6'b000100, 6'h00, 3);
        set_vec(9, "j",    6'b000010, 6'h00, 3);

        bus.OpCode = 6'h23; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
        do_reset();

        // First fetch after reset
        @(negedge clk);
        chk("first_fetch_state", 32'(bus.state), 0);
        chk("first_fetch_irwrite", 32'(bus.IRWrite), 1);
        chk("first_fetch_pcen", 32'(bus.PCEn), 1);
        // lw interrupted by reset while stalled in MEMREAD
        step(); step(); step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("lw_stall_state", 32'(bus.state), 3);
        chk("lw_stall_regwrite", 32'(bus.RegWrite), 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_regwrite", 32'(bus.RegWrite), 0);
        step();
        rst = 1'b0;
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_retired", bus.retired, ret_model);

        // Table: cycle count and retirement with memory always ready
        for (int i = 0; i < 10; i++) begin
            bus.OpCode = tbl[i].op; bus.Funct = tbl[i].fn; bus.mem_ready = 1'b1;
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (bus.state != 4'd0 && cnt < 20);
            chk({tbl[i].name, "_cycles"}, cnt, tbl[i].cycles);
            ret_model++;
            chk({tbl[i].name, "_retired"}, bus.retired, ret_model);
        end

        // sw with three not-ready cycles in MEMWR
        bus.OpCode = 6'b101011; bus.mem_ready = 1'b1;
        step(); step(); step();
        mwc = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            @(negedge clk);
            chk("sw_wait_state", 32'(bus.state), 5);
            chk("sw_iord", 32'(bus.IorD), 1);
            if (bus.MemWrite) mwc++;
            step();
        end
        chk("sw_memwrite_cycles", mwc, 4);
        chk("sw_exit_state", 32'(bus.state), 0);
        ret_model++;
        chk("sw_retired", bus.retired, ret_model);

        // beq taken then not taken
        for (int zz = 0; zz < 2; zz++) begin
            bus.OpCode = 6'b000100; bus.mem_ready = 1'b1;
            step(); step();
            bus.Zero = (zz == 0);
            @(negedge clk);
            chk("beq_state", 32'(bus.state), 8);
            chk("beq_pcen", 32'(bus.PCEn), (zz == 0) ? 1 : 0);
            chk("beq_pcsrc", 32'(bus.PCSrc), 1);
            chk("beq_alu", 32'(bus.ALUControl), 6);
            step();
            ret_model++;
            chk("beq_retired", bus.retired, ret_model);
        end

        // slt through EXECUTE / ALUWB
        bus.OpCode = 6'b000000; bus.Funct = 6'h2a;
        step(); step();
        @(negedge clk);
        chk("slt_exec_state", 32'(bus.state), 6);
        chk("slt_alu", 32'(bus.ALUControl), 7);
        step();
        @(negedge clk);
        chk("slt_wb_state", 32'(bus.state), 7);
        chk("slt_regdst", 32'(bus.RegDst), 1);
        step();
        ret_model++;
        chk("slt_retired", bus.retired, ret_model);

        // bne opcode
        bus.OpCode = 6'b000101; bus.Zero = 1'b0;
        step(); step();
        @(negedge clk);
`ifdef MULTICYCLE_CU_BNE_EN
        chk("bne_state", 32'(bus.state), 8);
        chk("bne_pcen", 32'(bus.PCEn), 1);
        step();
        ret_model++;
        chk("bne_retired", bus.retired, ret_model);
`else
        chk("bne_illegal_state", 32'(bus.state), 12);
        step();
        do_reset();
`endif

        // Unsupported funct parks in ILLEGAL until reset
        bus.OpCode = 6'b000000; bus.Funct = 6'h03;
        step(); step();
        repeat (4) begin
            @(negedge clk);
            chk("badfn_state", 32'(bus.state), 12);
            chk("badfn_illegal", 32'(bus.illegal), 1);
            chk("badfn_regwrite", 32'(bus.RegWrite), 0);
            chk("badfn_retired", bus.retired, ret_model);
            step();
        end
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 7);
            fn  = 6'($urandom_range(0, 63));
            case (cls)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; fn = r_fns[$urandom_range(0, 4)]; end
                3: op = 6'b001000;
                4: op = 6'b000100;
                5: op = 6'b000010;
                6: op = ill_ops[$urandom_range(0, 3)];
                default: begin op = 6'b000000; fn = 6'h03; end
            endcase
            run_instr(op, fn, cls);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation MIPS control unit for the multicycle datapath: one shared memory, IR/MDR/A/B/ALUOut registers, one ALU reused across steps.
- Replaces the combinational main/ALU decoder pair with a Moore FSM. Write enables and PC enable are gated by a memory-ready handshake.
- Adds illegal-instruction detection and a retired-instruction counter.
- Sits between the instruction register, the ALU Zero flag and the datapath muxes/enables.

Parameters:
ALUCTRL_W, 3, ALUControl width (>=3); codes occupy bits [2:0], upper bits driven 0
CNT_W, 32, width of retired-instruction counter
ILLEGAL_HALT, 1, 1: park in ILLEGAL until reset; 0: flag for one cycle then refetch

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
OpCode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
IorD  out  1  memory address select (0 PC, 1 ALUOut)
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  write register select (1 rd, 0 rt)
MemtoReg  out  1  write-back select (1 MDR, 0 ALUOut)
RegWrite  out  1  register file write
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
ALUControl  out  ALUCTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
PCEn  out  1  PC load = PCWrite | (Branch & Zero)
state  out  4  current state encoding (debug)
illegal  out  1  unsupported opcode/funct decoded
retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12. Codes 13-15 are unreachable and go to FETCH.
- Reset: state=FETCH, retired=0, illegal=0. While rst=1, MemWrite, IRWrite, RegWrite and PCEn are forced 0.
- Outputs are Moore, decoded from state. Exception: IRWrite, PCWrite and MemWrite-completion are qualified by mem_ready where noted. Any output not listed for a state is 0.
- FETCH: IorD=0, SrcA=0, SrcB=01, add, PCSrc=00; IRWrite=PCWrite=mem_ready. Hold while mem_ready=0; go to DECODE when 1.
- DECODE: SrcA=0, SrcB=11, add (branch target into ALUOut). Next state by OpCode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - others -> ILLEGAL
  - R-type with Funct not in {100000, 100010, 100100, 100101, 101010} -> ILLEGAL
- MEMADR: SrcA=1, SrcB=10, add. Goes to MEMREAD for lw, MEMWR for sw.
- MEMREAD: IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
- MEMWR: IorD=1, MemWrite=1 held for every cycle in the state; leave to FETCH on mem_ready.
- EXECUTE: SrcA=1, SrcB=00, ALUControl from Funct (add, sub, and, or, slt as above).
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
- BRANCH: SrcA=1, SrcB=00, sub, PCSrc=01, Branch=1.
- ADDIEX: SrcA=1, SrcB=10, add.
- ADDIWB: RegDst=0, RegWrite=1.
- JUMP: PCSrc=10, PCWrite=1.
- Completion: MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB and JUMP return to FETCH and increment retired by 1, wrapping modulo 2^CNT_W.
- ILLEGAL: illegal=1, no write enables asserted, retired unchanged.
  - ILLEGAL_HALT=1: stay in ILLEGAL until rst.
  - ILLEGAL_HALT=0: one cycle, then FETCH.
- Cycle counts with mem_ready held 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- rst asserted in any state, including mid-wait, returns to FETCH on the next edge. No write occurs in the reset cycle.

Optional Feature:
MULTICYCLE_CU_BNE_EN
- Defined: OpCode 000101 (bne) is decoded DECODE -> BRANCH. Branch condition becomes Zero XNOR is_beq, latched as a 1-bit flag in DECODE, so PCEn = PCWrite | (Branch & (Zero ^ bne_flag)).
- Undefined: 000101 goes to ILLEGAL; no flag register exists.

Test Plan:
- rst=1 for 2 cycles then release, mem_ready=1 -> state=0, retired=0, IRWrite=1 and PCEn=1 in first FETCH cycle.
- lw (OpCode 100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired +1.
- sw with mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, IorD=1, exit to FETCH after mem_ready=1; retired +1.
- beq, Zero=1 then Zero=0 -> PCEn=1 with PCSrc=01 in BRANCH for first, PCEn=0 for second; ALUControl=110.
- R-type Funct 101010 -> ALUControl=111 in EXECUTE, RegDst=1 in ALUWB. Funct 000011 -> ILLEGAL: illegal=1, held until rst (ILLEGAL_HALT=1), retired unchanged.
- rst asserted in MEMREAD with mem_ready=0 -> next cycle state=0, RegWrite never asserted, retired unchanged.
